// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and widths for the data-RAM port arbiter and the memory-write stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_port_arbiter_pkg;

  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_MAX     = 8;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1,
    COOL   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_AUX  = 2'd2
  } gnt_owner_e;

endpackage

// File: rtl/ram_port_mux.sv
// Steers the granted requester's address, write data and write strobe onto the RAM port.
// Latency: purely combinational.
// Backpressure: none; drives zeros when nobody owns the port.
// Ports: owner (gnt_owner_e code), pipe_*/aux_* request operands, *_ram RAM-side outputs.
module ram_port_mux #(
  parameter int ADDR_W = ram_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W = ram_port_arbiter_pkg::DATA_W
) (
  input  logic [1:0]        owner,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [ADDR_W-1:0] addr_ram,
  output logic [DATA_W-1:0] write_data_ram,
  output logic              write_ram
);
  import ram_port_arbiter_pkg::*;

  always_comb begin
    addr_ram       = '0;
    write_data_ram = '0;
    write_ram      = 1'b0;
    case (owner)
      GNT_PIPE: begin
        addr_ram       = pipe_addr;
        write_data_ram = pipe_wdata;
        write_ram      = pipe_we;
      end
      GNT_AUX: begin
        addr_ram       = aux_addr;
        write_data_ram = aux_wdata;
        write_ram      = aux_we;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single data-RAM port between the pipeline memory stage and the aux requester.
// Latency: grant is same-cycle combinational; read data returns one cycle after the grant.
// Backpressure: pipe_stall / !aux_gnt tell the loser to hold its request; aux starvation is capped.
// Ports: clk/rst (async active-low), pipe_* and aux_* requester sides, *_ram RAM side.
module ram_port_arbiter #(
  parameter int ADDR_W       = ram_port_arbiter_pkg::ADDR_W,
  parameter int DATA_W       = ram_port_arbiter_pkg::DATA_W,
  parameter int STARVE_LIMIT = ram_port_arbiter_pkg::STARVE_LIMIT,
  parameter int LOCK_MAX     = ram_port_arbiter_pkg::LOCK_MAX,
  parameter int CNT_W        = ram_port_arbiter_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_rvalid,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic              aux_lock,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_rvalid,
  output logic [ADDR_W-1:0] addr_ram,
  output logic [DATA_W-1:0] write_data_ram,
  output logic              write_ram,
  input  logic [DATA_W-1:0] read_data_ram
);
  import ram_port_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LOCK_END   = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  arb_state_e       state, state_nxt;
  gnt_owner_e       owner;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic [CNT_W-1:0] lock_cnt, lock_nxt;
  logic             pipe_gnt;

  always_comb begin
    owner     = GNT_NONE;
    state_nxt = state;
    lock_nxt  = '0;
    case (state)
      ARB: begin
        if (aux_req && (!pipe_req || starve_cnt == STARVE_MAX)) begin
          owner = GNT_AUX;
          if (aux_lock) begin
            state_nxt = LOCKED;
            lock_nxt  = CNT_ONE;
          end
        end else if (pipe_req) begin
          owner = GNT_PIPE;
        end
      end
      LOCKED: begin
        if (aux_req && aux_lock) begin
          owner = GNT_AUX;
          // lock_cnt counts burst grants so far, including the ARB grant that opened it.
          if (lock_cnt + CNT_ONE == LOCK_END) begin
            state_nxt = COOL;
          end else begin
            lock_nxt = lock_cnt + CNT_ONE;
          end
        end else begin
          // Drop cycle: pipe is held off one more cycle so the lock release is clean.
          state_nxt = COOL;
          if (aux_req && !pipe_req) owner = GNT_AUX;
        end
      end
      COOL: begin
        state_nxt = ARB;
        if (pipe_req)     owner = GNT_PIPE;
        else if (aux_req) owner = GNT_AUX;
      end
      default: state_nxt = ARB;
    endcase
    // Nothing may touch the RAM while reset is asserted.
    if (!rst) owner = GNT_NONE;
  end

  assign pipe_gnt   = (owner == GNT_PIPE);
  assign aux_gnt    = (owner == GNT_AUX);
  assign pipe_stall = rst && pipe_req && !pipe_gnt;
  assign pipe_rdata = read_data_ram;
  assign aux_rdata  = read_data_ram;

  always_comb begin
    starve_nxt = '0;
    if (aux_req && !aux_gnt) begin
      starve_nxt = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ARB;
      starve_cnt  <= '0;
      lock_cnt    <= '0;
      pipe_rvalid <= 1'b0;
      aux_rvalid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      starve_cnt  <= starve_nxt;
      lock_cnt    <= lock_nxt;
      pipe_rvalid <= pipe_gnt && !pipe_we;
      aux_rvalid  <= aux_gnt && !aux_we;
    end
  end

  ram_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .owner         (owner),
    .pipe_we       (pipe_we),
    .pipe_addr     (pipe_addr),
    .pipe_wdata    (pipe_wdata),
    .aux_we        (aux_we),
    .aux_addr      (aux_addr),
    .aux_wdata     (aux_wdata),
    .addr_ram      (addr_ram),
    .write_data_ram(write_data_ram),
    .write_ram     (write_ram)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a one-cycle synchronous RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        pipe_req, pipe_we;
  logic [8:0]  pipe_addr;
  logic [15:0] pipe_wdata;
  logic        pipe_stall;
  logic [15:0] pipe_rdata;
  logic        pipe_rvalid;
  logic        aux_req, aux_we, aux_lock;
  logic [8:0]  aux_addr;
  logic [15:0] aux_wdata;
  logic        aux_gnt;
  logic [15:0] aux_rdata;
  logic        aux_rvalid;
  logic [8:0]  addr_ram;
  logic [15:0] write_data_ram;
  logic        write_ram;
  logic [15:0] read_data_ram;

  logic [15:0] mem [0:511];
  int n_cmp;
  int n_err;

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata), .pipe_rvalid(pipe_rvalid),
    .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .addr_ram(addr_ram), .write_data_ram(write_data_ram), .write_ram(write_ram),
    .read_data_ram(read_data_ram)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: read-before-write, one-cycle read latency; preloads 0x012 while reset is low.
  always @(posedge clk) begin
    if (!rst) begin
      mem[9'h012] <= 16'hBEEF;
    end else if (write_ram) begin
      mem[addr_ram] <= write_data_ram;
    end
    read_data_ram <= mem[addr_ram];
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_req = 0; pipe_we = 0; pipe_addr = '0; pipe_wdata = '0;
    aux_req = 0; aux_we = 0; aux_lock = 0; aux_addr = '0; aux_wdata = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    pipe_req = 1; aux_req = 1; aux_we = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("rst_aux_gnt", 32'(aux_gnt), 32'd0);
    chk("rst_write_ram", 32'(write_ram), 32'd0);
    chk("rst_pipe_rvalid", 32'(pipe_rvalid), 32'd0);
    chk("rst_aux_rvalid", 32'(aux_rvalid), 32'd0);
    chk("rst_addr_ram", 32'(addr_ram), 32'd0);
    idle_inputs();
    #2 rst = 1'b1;

    // Pipe-only read of preloaded 0x012.
    nxt();
    pipe_req = 1; pipe_we = 0; pipe_addr = 9'h012;
    #1;
    chk("rd_write_ram", 32'(write_ram), 32'd0);
    chk("rd_addr_ram", 32'(addr_ram), 32'h012);
    chk("rd_pipe_stall", 32'(pipe_stall), 32'd0);
    nxt();
    pipe_req = 0;
    #1;
    chk("rd_pipe_rvalid", 32'(pipe_rvalid), 32'd1);
    chk("rd_pipe_rdata", 32'(pipe_rdata), 32'hBEEF);
    chk("rd_aux_rvalid", 32'(aux_rvalid), 32'd0);

    // Starvation: aux force-granted on the fifth contended cycle.
    nxt();
    pipe_req = 1; pipe_we = 0; pipe_addr = 9'h001;
    aux_req = 1; aux_we = 0; aux_addr = 9'h002;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) nxt();
      #1;
      chk("stv_aux_gnt_low", 32'(aux_gnt), 32'd0);
      chk("stv_pipe_stall_low", 32'(pipe_stall), 32'd0);
      chk("stv_addr_pipe", 32'(addr_ram), 32'h001);
    end
    nxt();
    #1;
    chk("stv_aux_gnt_c4", 32'(aux_gnt), 32'd1);
    chk("stv_pipe_stall_c4", 32'(pipe_stall), 32'd1);
    chk("stv_addr_aux", 32'(addr_ram), 32'h002);
    nxt();
    aux_req = 0;
    #1;
    chk("stv_starve_cnt_c5", 32'(dut.starve_cnt), 32'd0);
    chk("stv_pipe_stall_c5", 32'(pipe_stall), 32'd0);
    chk("stv_aux_rvalid_c5", 32'(aux_rvalid), 32'd1);
    chk("stv_pipe_rvalid_c5", 32'(pipe_rvalid), 32'd0);
    nxt();
    idle_inputs();

    // Locked aux write burst, capped at eight grants.
    nxt();
    aux_req = 1; aux_lock = 1; aux_we = 1; aux_addr = 9'h100; aux_wdata = 16'h5000;
    #1;
    chk("lk_aux_gnt_0", 32'(aux_gnt), 32'd1);
    chk("lk_write_ram_0", 32'(write_ram), 32'd1);
    for (int i = 1; i < 8; i++) begin
      nxt();
      pipe_req = 1; pipe_we = 0; pipe_addr = 9'h003;
      aux_addr = 9'(9'h100 + i); aux_wdata = 16'(16'h5000 + i);
      #1;
      chk("lk_aux_gnt", 32'(aux_gnt), 32'd1);
      chk("lk_pipe_stall", 32'(pipe_stall), 32'd1);
      chk("lk_wdata", 32'(write_data_ram), 32'(16'h5000 + i));
    end
    nxt();
    #1;
    chk("lk_cool_aux_gnt", 32'(aux_gnt), 32'd0);
    chk("lk_cool_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("lk_cool_write_ram", 32'(write_ram), 32'd0);
    chk("lk_cool_state", 32'(dut.state), 32'(COOL));
    nxt();
    #1;
    chk("lk_arb_state", 32'(dut.state), 32'(ARB));
    chk("lk_arb_aux_gnt", 32'(aux_gnt), 32'd0);
    chk("lk_arb_pipe_stall", 32'(pipe_stall), 32'd0);
    nxt();
    idle_inputs();
    nxt();

    // Lock released after three grants while pipe waits.
    nxt();
    aux_req = 1; aux_lock = 1; aux_we = 1; aux_addr = 9'h110; aux_wdata = 16'h6000;
    #1;
    chk("dr_aux_gnt_0", 32'(aux_gnt), 32'd1);
    nxt();
    pipe_req = 1; pipe_we = 0; pipe_addr = 9'h003;
    #1;
    chk("dr_aux_gnt_1", 32'(aux_gnt), 32'd1);
    chk("dr_pipe_stall_1", 32'(pipe_stall), 32'd1);
    nxt();
    #1;
    chk("dr_aux_gnt_2", 32'(aux_gnt), 32'd1);
    nxt();
    aux_req = 0; aux_lock = 0;
    #1;
    chk("dr_drop_aux_gnt", 32'(aux_gnt), 32'd0);
    chk("dr_drop_pipe_stall", 32'(pipe_stall), 32'd1);
    chk("dr_drop_write_ram", 32'(write_ram), 32'd0);
    nxt();
    #1;
    chk("dr_cool_pipe_stall", 32'(pipe_stall), 32'd0);
    chk("dr_cool_addr", 32'(addr_ram), 32'h003);
    nxt();
    idle_inputs();
    nxt();

    // Same-address collision: pipe wins, aux later reads the pipe's data.
    nxt();
    pipe_req = 1; pipe_we = 1; pipe_addr = 9'h0A0; pipe_wdata = 16'h1111;
    aux_req = 1; aux_we = 1; aux_addr = 9'h0A0; aux_wdata = 16'h2222;
    #1;
    chk("col_write_ram", 32'(write_ram), 32'd1);
    chk("col_wdata", 32'(write_data_ram), 32'h1111);
    chk("col_addr", 32'(addr_ram), 32'h0A0);
    chk("col_aux_gnt", 32'(aux_gnt), 32'd0);
    nxt();
    pipe_req = 0; pipe_we = 0;
    aux_we = 0;
    #1;
    chk("col_rd_aux_gnt", 32'(aux_gnt), 32'd1);
    chk("col_rd_write_ram", 32'(write_ram), 32'd0);
    nxt();
    aux_req = 0;
    #1;
    chk("col_aux_rvalid", 32'(aux_rvalid), 32'd1);
    chk("col_aux_rdata", 32'(aux_rdata), 32'h1111);

    // Reset during a locked read burst.
    nxt();
    aux_req = 1; aux_lock = 1; aux_we = 0; aux_addr = 9'h012;
    #1;
    chk("rl_aux_gnt_0", 32'(aux_gnt), 32'd1);
    nxt();
    pipe_req = 1; pipe_we = 0; pipe_addr = 9'h004;
    #1;
    chk("rl_pre_aux_rvalid", 32'(aux_rvalid), 32'd1);
    chk("rl_pre_aux_gnt", 32'(aux_gnt), 32'd1);
    chk("rl_pre_pipe_stall", 32'(pipe_stall), 32'd1);
    chk("rl_pre_state", 32'(dut.state), 32'(LOCKED));
    #1 rst = 1'b0;
    #1;
    chk("rl_aux_rvalid", 32'(aux_rvalid), 32'd0);
    chk("rl_aux_gnt", 32'(aux_gnt), 32'd0);
    chk("rl_write_ram", 32'(write_ram), 32'd0);
    chk("rl_pipe_stall", 32'(pipe_stall), 32'd0);
    idle_inputs();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rl_state", 32'(dut.state), 32'(ARB));
    chk("rl_starve_cnt", 32'(dut.starve_cnt), 32'd0);
    chk("rl_lock_cnt", 32'(dut.lock_cnt), 32'd0);
    nxt();
    chk("rl_post_aux_rvalid", 32'(aux_rvalid), 32'd0);
    chk("rl_post_pipe_rvalid", 32'(pipe_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
